// File: rtl/mem_scan_display.sv
// Debug viewer: steps an index through data memory or the register file and
// shows the addressed 32-bit word on an 8-digit multiplexed seven-segment display.
`timescale 1ns/1ps

module mem_scan_display #(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int REFRESH_CYCLES  = 100_000,
  parameter int AUTO_CYCLES     = 50_000_000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mode,
  input  logic        btn_next,
  input  logic        btn_prev,
  input  logic        auto_en,
  input  logic [31:0] data_s,
  input  logic [31:0] r_show,
  output logic [6:0]  sl,
  output logic [4:0]  reg_s,
  output logic [6:0]  idx_led,
  output logic [7:0]  an,
  output logic [7:0]  seg
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int RW = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
  localparam int AW = (AUTO_CYCLES > 1) ? $clog2(AUTO_CYCLES) : 1;
  localparam logic [DW-1:0] DB_MAX   = DW'(DEBOUNCE_CYCLES);
  localparam logic [RW-1:0] REF_MAX  = RW'(REFRESH_CYCLES - 1);
  localparam logic [AW-1:0] AUTO_MAX = AW'(AUTO_CYCLES - 1);

  // Button lanes: bit 0 = next, bit 1 = prev.
  logic [1:0]         btn_raw, sync1, sync2, db, db_q, armed, pulse, warm;
  logic [1:0][DW-1:0] db_cnt;

  assign btn_raw = {btn_prev, btn_next};

  // A lane is armed only once its synchronizer has refilled with live samples
  // and shows the button released, so a press held through reset never steps.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (reset) begin
      sync1  <= '0;
      sync2  <= '0;
      db     <= '0;
      db_q   <= '0;
      armed  <= '0;
      pulse  <= '0;
      warm   <= '0;
      db_cnt <= '0;
    end else begin
      sync1 <= btn_raw;
      sync2 <= sync1;
      db_q  <= db;
      warm  <= {warm[0], 1'b1};
      pulse <= db & ~db_q & armed;
      for (int b = 0; b < 2; b++) begin
        if (sync2[b] == db[b]) begin
          db_cnt[b] <= '0;
        end else if (db_cnt[b] == DB_MAX) begin
          db[b]     <= sync2[b];
          db_cnt[b] <= '0;
        end else begin
          db_cnt[b] <= db_cnt[b] + 1'b1;
        end
        if (warm[1] && !sync2[b]) armed[b] <= 1'b1;
      end
    end
  end

  logic            mode_q;
  logic [6:0]      idx, lim;
  logic [AW-1:0]   auto_cnt;
  logic            auto_tick, step_next, step_prev;

  // A manual pulse pre-empts a coincident auto tick.
  always_comb begin
    lim       = mode ? 7'd31 : 7'd127;
    auto_tick = auto_en && (auto_cnt == AUTO_MAX);
    step_next = pulse[0] | (auto_tick & ~(pulse[0] | pulse[1]));
    step_prev = pulse[1];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      idx      <= '0;
      auto_cnt <= '0;
      mode_q   <= mode;
    end else begin
      mode_q <= mode;
      if (mode != mode_q) begin
        idx      <= '0;
        auto_cnt <= '0;
      end else begin
        if (!auto_en || auto_tick) auto_cnt <= '0;
        else                       auto_cnt <= auto_cnt + 1'b1;
        if (step_next && !step_prev)      idx <= (idx == lim) ? 7'd0 : idx + 7'd1;
        else if (step_prev && !step_next) idx <= (idx == 7'd0) ? lim : idx - 7'd1;
      end
    end
  end

  assign sl      = idx;
  assign reg_s   = idx[4:0];
  assign idx_led = idx;

  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: hex7 = 7'h40;  4'h1: hex7 = 7'h79;  4'h2: hex7 = 7'h24;  4'h3: hex7 = 7'h30;
      4'h4: hex7 = 7'h19;  4'h5: hex7 = 7'h12;  4'h6: hex7 = 7'h02;  4'h7: hex7 = 7'h78;
      4'h8: hex7 = 7'h00;  4'h9: hex7 = 7'h10;  4'hA: hex7 = 7'h08;  4'hB: hex7 = 7'h03;
      4'hC: hex7 = 7'h46;  4'hD: hex7 = 7'h21;  4'hE: hex7 = 7'h06;  default: hex7 = 7'h0E;
    endcase
  endfunction

  logic [31:0]   word;
  logic [RW-1:0] ref_cnt;
  logic [2:0]    dsel;

  // The decimal point over the top digit marks register-file view.
  always_ff @(posedge clk) begin
    if (reset) begin
      word    <= '0;
      ref_cnt <= '0;
      dsel    <= '0;
      an      <= 8'hFE;
      seg     <= 8'hC0;
    end else begin
      word <= mode ? r_show : data_s;
      if (ref_cnt == REF_MAX) begin
        ref_cnt <= '0;
        dsel    <= dsel + 3'd1;
      end else begin
        ref_cnt <= ref_cnt + 1'b1;
      end
      an  <= ~(8'd1 << dsel);
      seg <= {~(mode && (dsel == 3'd7)), hex7(word[{dsel, 2'b00} +: 4])};
    end
  end

endmodule
